// File: rtl/svc_rv_btb.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Lookup result is registered one cycle after sampling; training comes from EX.
module svc_rv_btb #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 16,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            lookup_en,
  input  logic [XLEN-1:0] lookup_pc,
  output logic            btb_hit,
  output logic [XLEN-1:0] btb_target,
  output logic            btb_taken,
  input  logic            update_en,
  input  logic [XLEN-1:0] update_pc,
  input  logic [XLEN-1:0] update_target,
  input  logic            update_taken,
  input  logic            update_is_jump,
  input  logic            invalidate
);

  localparam int TAG_W = XLEN - IDX_W - 2;

  function automatic logic [1:0] sat_inc(input logic [1:0] c);
    return (c == 2'b11) ? 2'b11 : c + 2'b01;
  endfunction

  function automatic logic [1:0] sat_dec(input logic [1:0] c);
    return (c == 2'b00) ? 2'b00 : c - 2'b01;
  endfunction

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [TAG_W-1:0] tag_q [DEPTH];
  logic [TAG_W-1:0] tag_d [DEPTH];
  logic [XLEN-1:0]  tgt_q [DEPTH];
  logic [XLEN-1:0]  tgt_d [DEPTH];
  logic [1:0]       ctr_q [DEPTH];
  logic [1:0]       ctr_d [DEPTH];

  logic            btb_hit_q, btb_hit_d;
  logic [XLEN-1:0] btb_target_q, btb_target_d;
  logic            btb_taken_q, btb_taken_d;

  logic [IDX_W-1:0] upd_idx, lkp_idx;
  logic [TAG_W-1:0] upd_tag, lkp_tag;
  logic             upd_hit, upd_taken_eff, lkp_hit;

  // Low PC bits never participate in addressing.
  logic unused_pc_lsbs;
  assign unused_pc_lsbs = ^{lookup_pc[1:0], update_pc[1:0]};

  assign upd_idx       = update_pc[IDX_W+1:2];
  assign upd_tag       = update_pc[XLEN-1:IDX_W+2];
  assign lkp_idx       = lookup_pc[IDX_W+1:2];
  assign lkp_tag       = lookup_pc[XLEN-1:IDX_W+2];
  assign upd_taken_eff = update_taken | update_is_jump;

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    tgt_d   = tgt_q;
    ctr_d   = ctr_q;
    upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    if (invalidate) begin
      valid_d = '0;
    end else if (update_en) begin
      if (upd_hit) begin
        if (upd_taken_eff) begin
          ctr_d[upd_idx] = sat_inc(ctr_q[upd_idx]);
          tgt_d[upd_idx] = update_target;
        end else begin
          ctr_d[upd_idx] = sat_dec(ctr_q[upd_idx]);
        end
        if (update_is_jump) ctr_d[upd_idx] = 2'b11;
      end else if (upd_taken_eff) begin
        valid_d[upd_idx] = 1'b1;
        tag_d[upd_idx]   = upd_tag;
        tgt_d[upd_idx]   = update_target;
        ctr_d[upd_idx]   = update_is_jump ? 2'b11 : 2'b10;
      end
    end
  end

  // Lookup reads the post-update entry so a same-cycle write is seen (write-first).
  always_comb begin
    lkp_hit      = valid_d[lkp_idx] && (tag_d[lkp_idx] == lkp_tag);
    btb_hit_d    = btb_hit_q;
    btb_target_d = btb_target_q;
    btb_taken_d  = btb_taken_q;
    if (lookup_en) begin
      btb_hit_d    = lkp_hit;
      btb_target_d = lkp_hit ? tgt_d[lkp_idx] : '0;
      btb_taken_d  = lkp_hit && ctr_d[lkp_idx][1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q      <= '0;
      btb_hit_q    <= 1'b0;
      btb_target_q <= '0;
      btb_taken_q  <= 1'b0;
    end else begin
      valid_q      <= valid_d;
      btb_hit_q    <= btb_hit_d;
      btb_target_q <= btb_target_d;
      btb_taken_q  <= btb_taken_d;
    end
  end

  always_ff @(posedge clk) begin
    tag_q <= tag_d;
    tgt_q <= tgt_d;
    ctr_q <= ctr_d;
  end

  assign btb_hit    = btb_hit_q;
  assign btb_target = btb_target_q;
  assign btb_taken  = btb_taken_q;

endmodule

// File: tb/tb_svc_rv_btb.sv
// Directed bench for svc_rv_btb: expected lookup results queued at drive time,
// popped and compared one cycle later.
module tb_svc_rv_btb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        lookup_en = 1'b0;
  logic [31:0] lookup_pc = '0;
  logic        btb_hit;
  logic [31:0] btb_target;
  logic        btb_taken;
  logic        update_en = 1'b0;
  logic [31:0] update_pc = '0;
  logic [31:0] update_target = '0;
  logic        update_taken = 1'b0;
  logic        update_is_jump = 1'b0;
  logic        invalidate = 1'b0;

  typedef struct packed {
    logic        hit;
    logic [31:0] tgt;
    logic        tk;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;

  svc_rv_btb #(.XLEN(32), .DEPTH(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .lookup_en(lookup_en), .lookup_pc(lookup_pc),
    .btb_hit(btb_hit), .btb_target(btb_target), .btb_taken(btb_taken),
    .update_en(update_en), .update_pc(update_pc), .update_target(update_target),
    .update_taken(update_taken), .update_is_jump(update_is_jump),
    .invalidate(invalidate)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input exp_t e);
    check({tag, ".hit"},    {31'b0, btb_hit},   {31'b0, e.hit});
    check({tag, ".target"}, btb_target,         e.tgt);
    check({tag, ".taken"},  {31'b0, btb_taken}, {31'b0, e.tk});
  endtask

  // Drive one cycle's inputs (called at posedge+1), advance one edge, then
  // compare against the queued expectation if a lookup was issued.
  task automatic cycle(input string tag,
                       input logic lk, input logic [31:0] lpc,
                       input logic up, input logic [31:0] upc, input logic [31:0] utgt,
                       input logic utk, input logic ujmp, input logic inv,
                       input logic ehit, input logic [31:0] etgt, input logic etk);
    exp_t e;
    lookup_en = lk; lookup_pc = lpc;
    update_en = up; update_pc = upc; update_target = utgt;
    update_taken = utk; update_is_jump = ujmp; invalidate = inv;
    if (lk) exp_q.push_back('{hit: ehit, tgt: etgt, tk: etk});
    @(posedge clk); #1;
    if (lk) begin
      e = exp_q.pop_front();
      check_outputs(tag, e);
    end
    lookup_en = 1'b0; update_en = 1'b0; invalidate = 1'b0;
    update_taken = 1'b0; update_is_jump = 1'b0;
  endtask

  task automatic upd(input logic [31:0] pc, input logic [31:0] tgt, input logic tk, input logic jmp);
    cycle("upd", 1'b0, 32'h0, 1'b1, pc, tgt, tk, jmp, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic look(input string tag, input logic [31:0] pc,
                      input logic ehit, input logic [31:0] etgt, input logic etk);
    cycle(tag, 1'b1, pc, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, ehit, etgt, etk);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_outputs("reset", '{hit: 1'b0, tgt: 32'h0, tk: 1'b0});
    rst_n = 1'b1;
    @(posedge clk); #1;

    look("cold_miss", 32'h100, 1'b0, 32'h0, 1'b0);
    upd(32'h100, 32'h80, 1'b1, 1'b0);
    look("alloc_wt", 32'h100, 1'b1, 32'h80, 1'b1);

    upd(32'h100, 32'h80, 1'b0, 1'b0);
    upd(32'h100, 32'h80, 1'b0, 1'b0);
    look("ctr0", 32'h100, 1'b1, 32'h80, 1'b0);
    upd(32'h100, 32'h80, 1'b0, 1'b0);
    upd(32'h100, 32'h80, 1'b1, 1'b0);
    look("ctr1_from_sat0", 32'h100, 1'b1, 32'h80, 1'b0);
    upd(32'h100, 32'h80, 1'b1, 1'b0);
    upd(32'h100, 32'h80, 1'b1, 1'b0);
    upd(32'h100, 32'h80, 1'b1, 1'b0);
    look("ctr3", 32'h100, 1'b1, 32'h80, 1'b1);
    upd(32'h100, 32'h80, 1'b0, 1'b0);
    look("ctr2_from_sat3", 32'h100, 1'b1, 32'h80, 1'b1);

    upd(32'h140, 32'h200, 1'b1, 1'b0);
    look("alias_old", 32'h100, 1'b0, 32'h0, 1'b0);
    look("alias_new", 32'h140, 1'b1, 32'h200, 1'b1);

    upd(32'h44, 32'h1000, 1'b1, 1'b1);
    upd(32'h44, 32'h1000, 1'b0, 1'b0);
    upd(32'h44, 32'h1000, 1'b0, 1'b0);
    look("jmp_ctr1", 32'h44, 1'b1, 32'h1000, 1'b0);
    upd(32'h44, 32'h2000, 1'b1, 1'b1);
    look("jmp_force3", 32'h44, 1'b1, 32'h2000, 1'b1);

    upd(32'h88, 32'h900, 1'b0, 1'b0);
    look("nt_no_alloc", 32'h88, 1'b0, 32'h0, 1'b0);

    cycle("write_first", 1'b1, 32'h20, 1'b1, 32'h20, 32'h400, 1'b1, 1'b0, 1'b0,
          1'b1, 32'h400, 1'b1);
    for (int i = 0; i < 3; i++) begin
      lookup_en = 1'b0;
      lookup_pc = 32'h100 + 32'(i) * 32'h44;
      @(posedge clk); #1;
      check_outputs("hold", '{hit: 1'b1, tgt: 32'h400, tk: 1'b1});
    end

    cycle("inv_same_cycle", 1'b1, 32'h300, 1'b1, 32'h300, 32'h500, 1'b1, 1'b0, 1'b1,
          1'b0, 32'h0, 1'b0);
    look("inv_300", 32'h300, 1'b0, 32'h0, 1'b0);
    look("inv_140", 32'h140, 1'b0, 32'h0, 1'b0);
    look("inv_20",  32'h20,  1'b0, 32'h0, 1'b0);

    upd(32'h20, 32'h400, 1'b1, 1'b0);
    look("pre_rst_hit", 32'h20, 1'b1, 32'h400, 1'b1);
    #2 rst_n = 1'b0;
    #1 check_outputs("async_rst", '{hit: 1'b0, tgt: 32'h0, tk: 1'b0});
    @(posedge clk); #1;
    rst_n = 1'b1;
    look("post_rst_miss", 32'h20, 1'b0, 32'h0, 1'b0);

    check("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
